// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Two-master, one-slave arbiter for the pipelined memory bus
//   (Cyc/Stb/We/Ack/Stall). Master 0 is the instruction-cache line fill
//   (read-only), master 1 is the load/store unit. The grant is registered and
//   held for the whole Cyc assertion of a master, with round-robin on ties.
//   The granted master's signals pass combinationally to the bus. The other
//   master sees Stall=1 and Ack=0.
//
// Optional feature: define BUS_TIMEOUT_EN to abort a grant that has gone
//   TIMEOUT cycles without an Ack. The default build has no counter, and
//   MxError is tied to 0.
//
// Ports
//   Clock, Reset                 clock (rising edge), async active-low reset
//   M0Cycle/M0Strobe/M0Address   master 0 request (bus We forced 0)
//   M0DataOut/M0Acknowledge/M0Stall/M0Error   responses to master 0
//   M1Cycle/M1Strobe/M1ReadWrite/M1Address/M1DataIn/M1Select   master 1 request
//   M1DataOut/M1Acknowledge/M1Stall/M1Error   responses to master 1
//   BusCycle/BusStrobe/BusReadWrite/MemoryAddress/MemoryDataOut/BusSelect
//                                muxed bus request towards the slave
//   BusAcknowledge/BusStall/MemoryDataIn   slave responses
//
// State table
//   state   | meaning
//   IDLE    | no grant; bus driven to zeros, both masters stalled
//   GNT0    | master 0 owns the bus until it drops M0Cycle
//   GNT1    | master 1 owns the bus until it drops M1Cycle
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                M0Cycle,
   input  logic                M0Strobe,
   input  logic [ADDR_W-1:0]   M0Address,
   output logic [DATA_W-1:0]   M0DataOut,
   output logic                M0Acknowledge,
   output logic                M0Stall,
   output logic                M0Error,
   input  logic                M1Cycle,
   input  logic                M1Strobe,
   input  logic                M1ReadWrite,
   input  logic [ADDR_W-1:0]   M1Address,
   input  logic [DATA_W-1:0]   M1DataIn,
   input  logic [DATA_W/8-1:0] M1Select,
   output logic [DATA_W-1:0]   M1DataOut,
   output logic                M1Acknowledge,
   output logic                M1Stall,
   output logic                M1Error,
   output logic                BusCycle,
   output logic                BusStrobe,
   output logic                BusReadWrite,
   output logic [ADDR_W-1:0]   MemoryAddress,
   output logic [DATA_W-1:0]   MemoryDataOut,
   output logic [DATA_W/8-1:0] BusSelect,
   input  logic                BusAcknowledge,
   input  logic                BusStall,
   input  logic [DATA_W-1:0]   MemoryDataIn
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   last_grant_q, last_grant_d;
   logic   gnt_cyc;
   logic   timeout_hit;
   logic [1:0] blocked;
   logic   req0, req1;

   // Read data is broadcast unqualified; Ack/Stall carry the qualification.
   assign M0DataOut = MemoryDataIn;
   assign M1DataOut = MemoryDataIn;

   // The granted master still holds Cyc; this is the only time the bus is active.
   assign gnt_cyc = ((state_q == ST_GNT0) && M0Cycle) || ((state_q == ST_GNT1) && M1Cycle);

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       blocked_q, blocked_d;

   assign timeout_hit = gnt_cyc && !BusAcknowledge && (cnt_q == CNT_TC);
   assign blocked     = blocked_q;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_d != state_q) || BusAcknowledge) begin
         cnt_d = '0;
      end else if (gnt_cyc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A faulted master stays locked out until it lets go of Cyc.
   always_comb begin
      blocked_d = blocked_q & {M1Cycle, M0Cycle};
      if (timeout_hit) begin
         if (state_q == ST_GNT0) blocked_d[0] = 1'b1;
         if (state_q == ST_GNT1) blocked_d[1] = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt_q     <= '0;
         blocked_q <= 2'b00;
      end else begin
         cnt_q     <= cnt_d;
         blocked_q <= blocked_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_hit    = 1'b0;
   assign blocked        = 2'b00;
`endif

   assign req0 = M0Cycle && !blocked[0];
   assign req1 = M1Cycle && !blocked[1];

   // last=1 means master 1 was served last, so master 0 wins a tie.
   function automatic state_t pick(input logic r0, input logic r1, input logic last);
      state_t s;
      if (r0 && r1)  s = last ? ST_GNT0 : ST_GNT1;
      else if (r0)   s = ST_GNT0;
      else if (r1)   s = ST_GNT1;
      else           s = ST_IDLE;
      pick = s;
   endfunction

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // On release the next owner is chosen at the same edge, so handover has no dead cycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_GNT0: begin
            if (timeout_hit) begin
               state_d      = ST_IDLE;
               last_grant_d = 1'b0;
            end else if (!M0Cycle) begin
               last_grant_d = 1'b0;
               state_d      = pick(req0, req1, 1'b0);
            end
         end
         ST_GNT1: begin
            if (timeout_hit) begin
               state_d      = ST_IDLE;
               last_grant_d = 1'b1;
            end else if (!M1Cycle) begin
               last_grant_d = 1'b1;
               state_d      = pick(req0, req1, 1'b1);
            end
         end
         default: begin
            state_d = pick(req0, req1, last_grant_q);
         end
      endcase
   end

   // Outputs depend only on the registered state, so a grant change can never
   // leak a strobe from a master that does not own the bus.
   always_comb begin
      BusCycle      = 1'b0;
      BusStrobe     = 1'b0;
      BusReadWrite  = 1'b0;
      MemoryAddress = '0;
      MemoryDataOut = '0;
      BusSelect     = '0;
      M0Acknowledge = 1'b0;
      M1Acknowledge = 1'b0;
      M0Stall       = 1'b1;
      M1Stall       = 1'b1;
      M0Error       = 1'b0;
      M1Error       = 1'b0;
      case (state_q)
         ST_GNT0: begin
            BusCycle      = M0Cycle;
            BusStrobe     = M0Strobe;
            MemoryAddress = M0Address;
            // Line fills always read whole words.
            BusSelect     = '1;
            M0Acknowledge = BusAcknowledge;
            M0Stall       = BusStall;
            M0Error       = timeout_hit;
         end
         ST_GNT1: begin
            BusCycle      = M1Cycle;
            BusStrobe     = M1Strobe;
            BusReadWrite  = M1ReadWrite;
            MemoryAddress = M1Address;
            MemoryDataOut = M1DataIn;
            BusSelect     = M1Select;
            M1Acknowledge = BusAcknowledge;
            M1Stall       = BusStall;
            M1Error       = timeout_hit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          M0Cycle, M0Strobe;
   logic [AW-1:0] M0Address;
   logic [DW-1:0] M0DataOut;
   logic          M0Acknowledge, M0Stall, M0Error;
   logic          M1Cycle, M1Strobe, M1ReadWrite;
   logic [AW-1:0] M1Address;
   logic [DW-1:0] M1DataIn;
   logic [3:0]    M1Select;
   logic [DW-1:0] M1DataOut;
   logic          M1Acknowledge, M1Stall, M1Error;
   logic          BusCycle, BusStrobe, BusReadWrite;
   logic [AW-1:0] MemoryAddress;
   logic [DW-1:0] MemoryDataOut;
   logic [3:0]    BusSelect;
   logic          BusAcknowledge, BusStall;
   logic [DW-1:0] MemoryDataIn;

   int n_checks = 0;
   int n_fail   = 0;

   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
      .Clock(Clock), .Reset(Reset),
      .M0Cycle(M0Cycle), .M0Strobe(M0Strobe), .M0Address(M0Address),
      .M0DataOut(M0DataOut), .M0Acknowledge(M0Acknowledge), .M0Stall(M0Stall), .M0Error(M0Error),
      .M1Cycle(M1Cycle), .M1Strobe(M1Strobe), .M1ReadWrite(M1ReadWrite), .M1Address(M1Address),
      .M1DataIn(M1DataIn), .M1Select(M1Select),
      .M1DataOut(M1DataOut), .M1Acknowledge(M1Acknowledge), .M1Stall(M1Stall), .M1Error(M1Error),
      .BusCycle(BusCycle), .BusStrobe(BusStrobe), .BusReadWrite(BusReadWrite),
      .MemoryAddress(MemoryAddress), .MemoryDataOut(MemoryDataOut), .BusSelect(BusSelect),
      .BusAcknowledge(BusAcknowledge), .BusStall(BusStall), .MemoryDataIn(MemoryDataIn)
   );

   always #5 Clock = ~Clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_inputs();
      M0Cycle = 0; M0Strobe = 0; M0Address = '0;
      M1Cycle = 0; M1Strobe = 0; M1ReadWrite = 0; M1Address = '0; M1DataIn = '0; M1Select = '0;
      BusAcknowledge = 0; BusStall = 0; MemoryDataIn = '0;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Reset = 0;
      clear_inputs();
      @(negedge Clock);
      Reset = 1;
   endtask

   // Arbitration vectors applied from reset (IDLE, master 0 wins first tie).
   // own = which master should hold the bus after the edge (-1 = none).
   typedef struct {
      logic c0;
      logic c1;
      int   own;
   } vec_t;

   // Behavioural reference: owner as an integer plus who was served last.
   int m_owner;
   int m_last;

   task automatic model_edge(input logic c0, input logic c1);
      if (!(m_owner == 0 && c0) && !(m_owner == 1 && c1)) begin
         if (m_owner >= 0) m_last = m_owner;
         if (c0 && c1)  m_owner = 1 - m_last;
         else if (c0)   m_owner = 0;
         else if (c1)   m_owner = 1;
         else           m_owner = -1;
      end
   endtask

   task automatic model_check();
      logic          e_cyc, e_stb, e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_dat;
      logic [3:0]    e_sel;
      e_cyc = 0; e_stb = 0; e_we = 0; e_addr = '0; e_dat = '0; e_sel = '0;
      if (m_owner == 0) begin
         e_cyc = M0Cycle; e_stb = M0Strobe; e_addr = M0Address; e_sel = 4'hF;
      end else if (m_owner == 1) begin
         e_cyc = M1Cycle; e_stb = M1Strobe; e_we = M1ReadWrite;
         e_addr = M1Address; e_dat = M1DataIn; e_sel = M1Select;
      end
      chk("rnd_cyc",   BusCycle, e_cyc);
      chk("rnd_stb",   BusStrobe, e_stb);
      chk("rnd_we",    BusReadWrite, e_we);
      chk("rnd_addr",  MemoryAddress, e_addr);
      chk("rnd_wdata", MemoryDataOut, e_dat);
      chk("rnd_sel",   BusSelect, e_sel);
      chk("rnd_ack0",  M0Acknowledge, (m_owner == 0) ? BusAcknowledge : 1'b0);
      chk("rnd_ack1",  M1Acknowledge, (m_owner == 1) ? BusAcknowledge : 1'b0);
      chk("rnd_stall0", M0Stall, (m_owner == 0) ? BusStall : 1'b1);
      chk("rnd_stall1", M1Stall, (m_owner == 1) ? BusStall : 1'b1);
      chk("rnd_rdata0", M0DataOut, MemoryDataIn);
      chk("rnd_rdata1", M1DataOut, MemoryDataIn);
      chk("rnd_err",   {M0Error, M1Error}, 2'b00);
   endtask

   initial begin
      vec_t vecs[14];
      int   acks;
      int   noack_run;

      vecs[0]  = '{1, 1,  0};
      vecs[1]  = '{1, 1,  0};
      vecs[2]  = '{0, 1,  1};
      vecs[3]  = '{1, 1,  1};
      vecs[4]  = '{1, 0,  0};
      vecs[5]  = '{0, 0, -1};
      vecs[6]  = '{1, 1,  1};
      vecs[7]  = '{0, 0, -1};
      vecs[8]  = '{0, 1,  1};
      vecs[9]  = '{0, 1,  1};
      vecs[10] = '{1, 0,  0};
      vecs[11] = '{1, 1,  0};
      vecs[12] = '{0, 0, -1};
      vecs[13] = '{1, 0,  0};

      // ---- 1: reset with both masters requesting ----
      clear_inputs();
      Reset = 0;
      M0Cycle = 1; M0Strobe = 1; M1Cycle = 1; M1Strobe = 1;
      BusAcknowledge = 1;
      #2;
      chk("rst_buscyc", BusCycle, 1'b0);
      chk("rst_stb",    BusStrobe, 1'b0);
      chk("rst_stalls", {M0Stall, M1Stall}, 2'b11);
      chk("rst_acks",   {M0Acknowledge, M1Acknowledge}, 2'b00);
      @(negedge Clock);
      Reset = 1;
      BusAcknowledge = 0;
      tick();
      @(negedge Clock);
      chk("rst_gnt0_cyc",   BusCycle, 1'b1);
      chk("rst_gnt0_stall", {M0Stall, M1Stall}, 2'b01);

      // async reset mid-transfer: outputs idle before any clock edge
      @(posedge Clock);
      #2;
      Reset = 0;
      #1;
      chk("rst_async_cyc",   BusCycle, 1'b0);
      chk("rst_async_stall", {M0Stall, M1Stall}, 2'b11);

      // ---- table of arbitration decisions ----
      do_reset();
      M0Address = 32'h0000_A000;
      M1Address = 32'h0000_B000;
      for (int i = 0; i < 14; i++) begin
         tick();
         M0Cycle = vecs[i].c0; M0Strobe = vecs[i].c0;
         M1Cycle = vecs[i].c1; M1Strobe = vecs[i].c1;
         tick();
         M0Cycle = vecs[i].c0; M1Cycle = vecs[i].c1;
         @(negedge Clock);
         chk($sformatf("vec%0d_stall", i), {M1Stall, M0Stall},
             {vecs[i].own != 1, vecs[i].own != 0});
         chk($sformatf("vec%0d_addr", i), MemoryAddress,
             (vecs[i].own == 0) ? 32'h0000_A000 : (vecs[i].own == 1) ? 32'h0000_B000 : 32'h0);
         chk($sformatf("vec%0d_cyc", i), BusCycle, vecs[i].own >= 0);
      end

      // ---- 2: 8-beat line fill from 0x2000 ----
      do_reset();
      tick();
      M0Cycle = 1; M0Strobe = 1; M0Address = 32'h0000_2000; BusAcknowledge = 1;
      @(negedge Clock);
      chk("fill_latency", BusCycle, 1'b0);
      acks = 0;
      for (int b = 0; b < 8; b++) begin
         tick();
         M0Address = 32'h0000_2000 + 32'(4 * b);
         MemoryDataIn = 32'h1111_0000 + 32'(b);
         @(negedge Clock);
         chk($sformatf("fill_addr%0d", b), MemoryAddress, 32'h0000_2000 + 32'(4 * b));
         chk($sformatf("fill_rdata%0d", b), M0DataOut, 32'h1111_0000 + 32'(b));
         chk($sformatf("fill_we%0d", b), BusReadWrite, 1'b0);
         chk($sformatf("fill_m1stall%0d", b), M1Stall, 1'b1);
         if (M0Acknowledge) acks++;
      end
      chk("fill_ack_count", acks, 8);
      tick();
      M0Cycle = 0; M0Strobe = 0; BusAcknowledge = 0;
      tick();
      @(negedge Clock);
      chk("fill_release", BusCycle, 1'b0);

      // ---- 4: stalled store from master 1 ----
      do_reset();
      tick();
      M1Cycle = 1; M1Strobe = 1; M1ReadWrite = 1; M1Address = 32'h0000_1000;
      M1DataIn = 32'hDEAD_BEEF; M1Select = 4'b0011; BusStall = 1;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge Clock);
         chk($sformatf("st_stall%0d", i), M1Stall, 1'b1);
         chk($sformatf("st_bus%0d", i), {BusStrobe, BusReadWrite, MemoryAddress, BusSelect},
             {1'b1, 1'b1, 32'h0000_1000, 4'b0011});
         chk($sformatf("st_wdata%0d", i), MemoryDataOut, 32'hDEAD_BEEF);
         if (M1Acknowledge) acks++;
      end
      tick();
      BusStall = 0; BusAcknowledge = 1;
      @(negedge Clock);
      chk("st_accept", M1Stall, 1'b0);
      if (M1Acknowledge) acks++;
      tick();
      M1Cycle = 0; M1Strobe = 0; BusAcknowledge = 0;
      chk("st_ack_count", acks, 1);

      // ---- 5: master 1 requests in the middle of a master 0 burst ----
      do_reset();
      M0Address = 32'h0000_3000; M1Address = 32'h0000_4000;
      tick();
      M0Cycle = 1; M0Strobe = 1;
      tick();
      M1Cycle = 1; M1Strobe = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk($sformatf("pre_m1wait%0d", i), {M1Stall, M0Stall}, 2'b10);
         chk($sformatf("pre_addr%0d", i), MemoryAddress, 32'h0000_3000);
         tick();
      end
      M0Cycle = 0; M0Strobe = 0;
      @(negedge Clock);
      chk("pre_drop_cyc", BusCycle, 1'b0);
      tick();
      @(negedge Clock);
      chk("pre_handover", {BusCycle, M1Stall, M0Stall}, 3'b101);
      chk("pre_handover_addr", MemoryAddress, 32'h0000_4000);
      tick();
      M1Cycle = 0; M1Strobe = 0;

`ifdef BUS_TIMEOUT_EN
      // ---- 6: slave never acks master 0 ----
      do_reset();
      M0Address = 32'h0000_5000; M1Address = 32'h0000_6000;
      tick();
      M0Cycle = 1; M0Strobe = 1; M1Cycle = 1; M1Strobe = 1;
      for (int g = 1; g <= 16; g++) begin
         tick();
         @(negedge Clock);
         chk($sformatf("to_err%0d", g), {M0Error, M1Error}, {g == 16, 1'b0});
         chk($sformatf("to_cyc%0d", g), BusCycle, 1'b1);
      end
      tick();
      @(negedge Clock);
      chk("to_abort_cyc", {BusCycle, M0Error}, 2'b00);
      tick();
      @(negedge Clock);
      chk("to_m1_gnt", {BusCycle, M1Stall, M0Stall}, 3'b101);
      chk("to_m1_addr", MemoryAddress, 32'h0000_6000);
      tick();
      M1Cycle = 0; M1Strobe = 0;
      tick();
      @(negedge Clock);
      chk("to_m0_locked", BusCycle, 1'b0);
      M0Cycle = 0; M0Strobe = 0;
      tick();
      M0Cycle = 1; M0Strobe = 1;
      tick();
      @(negedge Clock);
      chk("to_m0_regrant", {BusCycle, M0Stall}, 2'b10);
      tick();
      M0Cycle = 0; M0Strobe = 0;
`endif

      // ---- randomized traffic against the reference model ----
      do_reset();
      m_owner = -1;
      m_last  = 1;
      noack_run = 0;
      for (int c = 0; c < 600; c++) begin
         tick();
         model_edge(M0Cycle, M1Cycle);
         if (M0Cycle) M0Cycle = ($urandom_range(3) != 0);
         else         M0Cycle = ($urandom_range(2) == 0);
         if (M1Cycle) M1Cycle = ($urandom_range(3) != 0);
         else         M1Cycle = ($urandom_range(2) == 0);
         M0Strobe    = M0Cycle & $urandom_range(1);
         M1Strobe    = M1Cycle & $urandom_range(1);
         M1ReadWrite = $urandom_range(1);
         M0Address   = $urandom;
         M1Address   = $urandom;
         M1DataIn    = $urandom;
         M1Select    = 4'($urandom);
         MemoryDataIn = $urandom;
         BusStall    = ($urandom_range(3) == 0);
         BusAcknowledge = $urandom_range(1);
         if (noack_run >= 6) BusAcknowledge = 1;
         noack_run = BusAcknowledge ? 0 : noack_run + 1;
         @(negedge Clock);
         model_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
